// File: rtl/stream_arbiter.sv
// Purpose : merges two producer request channels onto one registered consumer port.
//           Each channel has a small FIFO. A round-robin arbiter feeds the output stage.
//           Per-channel flushes squash matching-ID entries.
// Latency : a push on edge k can reach the output at edge k+1 at the earliest.
// Backpr. : out_stall_N is asserted while FIFO N is full. The output holds while
//           in_stall && out_valid. Flushes act every cycle regardless of in_stall.
// Ports   : clk/reset (sync, active-high); in_address_N/in_id_N/in_valid_N/out_stall_N and
//           flush_N/flush_id_N per channel; out_address/out_id/out_src/out_valid/in_stall
//           consumer side; squash_cnt saturating count of squashed live entries.
module stream_arbiter #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address_1,
    input  logic [ID_W-1:0]   in_id_1,
    input  logic              in_valid_1,
    output logic              out_stall_1,
    input  logic              flush_1,
    input  logic [ID_W-1:0]   flush_id_1,
    input  logic [ADDR_W-1:0] in_address_2,
    input  logic [ID_W-1:0]   in_id_2,
    input  logic              in_valid_2,
    output logic              out_stall_2,
    input  logic              flush_2,
    input  logic [ID_W-1:0]   flush_id_2,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_src,
    output logic              out_valid,
    input  logic              in_stall,
    output logic [7:0]        squash_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Channel-indexed views of the ports (index 0 = channel 1).
    logic [ADDR_W-1:0] in_addr [2];
    logic [ID_W-1:0]   in_id   [2];
    logic [ID_W-1:0]   fl_id   [2];
    logic [1:0]        in_vld;
    logic [1:0]        fl;

    assign in_addr[0] = in_address_1;
    assign in_addr[1] = in_address_2;
    assign in_id[0]   = in_id_1;
    assign in_id[1]   = in_id_2;
    assign fl_id[0]   = flush_id_1;
    assign fl_id[1]   = flush_id_2;
    assign in_vld     = {in_valid_2, in_valid_1};
    assign fl         = {flush_2, flush_1};

    // Storage: each entry is {addr, id, live}.
    logic [ADDR_W-1:0] mem_addr_q [2][DEPTH];
    logic [ID_W-1:0]   mem_id_q   [2][DEPTH];
    logic              mem_live_q [2][DEPTH];
    logic [PW-1:0]     rd_ptr_q   [2];
    logic [PW-1:0]     wr_ptr_q   [2];
    logic [CW-1:0]     count_q    [2];
    logic              rr_q;

    logic [ADDR_W-1:0] out_address_q;
    logic [ID_W-1:0]   out_id_q;
    logic              out_src_q;
    logic              out_valid_q;
    logic [7:0]        squash_cnt_q;
    logic [7:0]        squash_cnt_d;

    logic [1:0]        full, push, cand, dead_pop, pop;
    logic [DEPTH-1:0]  kill [2];
    logic              load, grant_any, winner, out_kill;

    always_comb begin
        full      = '0;
        push      = '0;
        cand      = '0;
        dead_pop  = '0;
        pop       = '0;
        kill[0]   = '0;
        kill[1]   = '0;
        for (int c = 0; c < 2; c++) begin
            logic nonempty;
            logic head_live;
            logic head_hit;
            nonempty    = (count_q[c] != '0);
            full[c]     = (count_q[c] == CW'(DEPTH));
            push[c]     = in_vld[c] && !full[c];
            head_live   = nonempty && mem_live_q[c][rd_ptr_q[c]];
            // A head being flushed this cycle must not slip out as a grant.
            head_hit    = fl[c] && (mem_id_q[c][rd_ptr_q[c]] == fl_id[c]);
            cand[c]     = head_live && !head_hit;
            dead_pop[c] = nonempty && !mem_live_q[c][rd_ptr_q[c]];
            for (int i = 0; i < DEPTH; i++) begin
                logic [PW-1:0] off;
                off = PW'(i) - rd_ptr_q[c];
                // Only slots inside the occupied window count as killed entries.
                kill[c][i] = fl[c] && (CW'(off) < count_q[c]) && mem_live_q[c][i]
                             && (mem_id_q[c][i] == fl_id[c]);
            end
        end

        load      = !out_valid_q || !in_stall;
        grant_any = load && (cand != 2'b00);
        // With both candidates rr picks; otherwise the only candidate wins.
        winner    = (cand == 2'b11) ? rr_q : cand[1];
        pop[0]    = dead_pop[0] || (grant_any && !winner);
        pop[1]    = dead_pop[1] || (grant_any && winner);

        out_kill  = out_valid_q && fl[out_src_q] && (out_id_q == fl_id[out_src_q]);
    end

    always_comb begin
        int unsigned kills;
        int unsigned sum;
        kills = out_kill ? 1 : 0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                kills += kill[c][i] ? 1 : 0;
            end
        end
        sum          = 32'(squash_cnt_q) + kills;
        squash_cnt_d = (sum > 32'd255) ? 8'd255 : sum[7:0];
    end

    // Control state; the FIFO payload below needs no reset because count gates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            rr_q          <= 1'b0;
            out_address_q <= '0;
            out_id_q      <= '0;
            out_src_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            squash_cnt_q  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                count_q[c] <= count_q[c] + CW'(push[c]) - CW'(pop[c]);
            end
            if (grant_any) begin
                out_address_q <= mem_addr_q[winner][rd_ptr_q[winner]];
                out_id_q      <= mem_id_q[winner][rd_ptr_q[winner]];
                out_src_q     <= winner;
                out_valid_q   <= 1'b1;
                rr_q          <= !winner;
            end else if (load || out_kill) begin
                out_valid_q   <= 1'b0;
            end
            squash_cnt_q <= squash_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[c][i]) mem_live_q[c][i] <= 1'b0;
            end
            // The write slot is never occupied, so it cannot collide with a kill.
            if (push[c]) begin
                mem_addr_q[c][wr_ptr_q[c]] <= in_addr[c];
                mem_id_q[c][wr_ptr_q[c]]   <= in_id[c];
                mem_live_q[c][wr_ptr_q[c]] <= !(fl[c] && (in_id[c] == fl_id[c]));
            end
        end
    end

    assign out_stall_1 = full[0];
    assign out_stall_2 = full[1];
    assign out_address = out_address_q;
    assign out_id      = out_id_q;
    assign out_src     = out_src_q;
    assign out_valid   = out_valid_q;
    assign squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_stream_arbiter.sv
module tb_stream_arbiter;
    localparam int AW = 32;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] in_address_1, in_address_2, out_address;
    logic [IW-1:0] in_id_1, in_id_2, flush_id_1, flush_id_2, out_id;
    logic          in_valid_1, in_valid_2, out_stall_1, out_stall_2;
    logic          flush_1, flush_2, out_src, out_valid, in_stall;
    logic [7:0]    squash_cnt;

    int vectors = 0;
    int miscompares = 0;

    stream_arbiter #(.ADDR_W(AW), .ID_W(IW), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_address_1(in_address_1), .in_id_1(in_id_1), .in_valid_1(in_valid_1),
        .out_stall_1(out_stall_1), .flush_1(flush_1), .flush_id_1(flush_id_1),
        .in_address_2(in_address_2), .in_id_2(in_id_2), .in_valid_2(in_valid_2),
        .out_stall_2(out_stall_2), .flush_2(flush_2), .flush_id_2(flush_id_2),
        .out_address(out_address), .out_id(out_id), .out_src(out_src),
        .out_valid(out_valid), .in_stall(in_stall), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_address_1 = '0; in_id_1 = '0; in_valid_1 = 1'b0; flush_1 = 1'b0; flush_id_1 = '0;
        in_address_2 = '0; in_id_2 = '0; in_valid_2 = 1'b0; flush_2 = 1'b0; flush_id_2 = '0;
        in_stall = 1'b0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset.out_valid got %b want 0", out_valid); end
        vectors++; if (out_address !== '0) begin miscompares++; $display("FAIL reset.out_address got %h want 0", out_address); end
        vectors++; if (out_id !== 8'h00) begin miscompares++; $display("FAIL reset.out_id got %h want 00", out_id); end
        vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL reset.out_src got %b want 0", out_src); end
        vectors++; if (out_stall_1 !== 1'b0) begin miscompares++; $display("FAIL reset.out_stall_1 got %b want 0", out_stall_1); end
        vectors++; if (out_stall_2 !== 1'b0) begin miscompares++; $display("FAIL reset.out_stall_2 got %b want 0", out_stall_2); end
        vectors++; if (squash_cnt !== 8'h00) begin miscompares++; $display("FAIL reset.squash_cnt got %0d want 0", squash_cnt); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        in_stall = 1'b1; in_valid_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_id_1 = 8'h90 + 8'(i);
            tick();
        end
        vectors++; if (out_stall_1 !== 1'b1) begin miscompares++; $display("FAIL rstmid.full got %b want 1", out_stall_1); end
        reset = 1'b1; idle_inputs(); tick(); reset = 1'b0;
        vectors++; if (out_stall_1 !== 1'b0) begin miscompares++; $display("FAIL rstmid.stall got %b want 0", out_stall_1); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid.valid got %b want 0", out_valid); end
    endtask

    task automatic test_single_channel;
        logic [7:0] ids [3];
        ids[0] = 8'h11; ids[1] = 8'h12; ids[2] = 8'h13;
        apply_reset();
        in_valid_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_id_1 = ids[i];
                in_address_1 = 32'hA000_0000 | 32'(ids[i]);
            end else begin
                in_valid_1 = 1'b0;
            end
            tick();
            if (i == 0) begin
                vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single.e0 valid got %b want 0", out_valid); end
            end else begin
                vectors++;
                if (out_valid !== 1'b1 || out_id !== ids[i-1] || out_src !== 1'b0
                    || out_address !== (32'hA000_0000 | 32'(ids[i-1]))) begin
                    miscompares++;
                    $display("FAIL single.e%0d got v=%b id=%h src=%b addr=%h want v=1 id=%h src=0", i, out_valid, out_id, out_src, out_address, ids[i-1]);
                end
            end
        end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single.drain valid got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin;
        logic [7:0] nxt1, nxt2, exp_id;
        logic       acc1, acc2, exp_src;
        apply_reset();
        nxt1 = 8'h20; nxt2 = 8'h30;
        in_valid_1 = 1'b1; in_valid_2 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_id_1 = nxt1; in_id_2 = nxt2;
            acc1 = !out_stall_1; acc2 = !out_stall_2;
            tick();
            if (acc1) nxt1++;
            if (acc2) nxt2++;
            if (k >= 1) begin
                exp_src = 1'((k - 1) % 2);
                exp_id  = exp_src ? 8'(8'h30 + (k - 1) / 2) : 8'(8'h20 + (k - 1) / 2);
                vectors++;
                if (out_valid !== 1'b1 || out_src !== exp_src || out_id !== exp_id) begin
                    miscompares++;
                    $display("FAIL rr.e%0d got v=%b src=%b id=%h want v=1 src=%b id=%h", k, out_valid, out_src, out_id, exp_src, exp_id);
                end
            end
        end
    endtask

    task automatic test_back_pressure;
        apply_reset();
        in_stall = 1'b1; in_valid_1 = 1'b1;
        in_id_1 = 8'h40; tick();
        in_id_1 = 8'h41; tick();
        in_id_1 = 8'h42; tick();
        in_id_1 = 8'h43;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_stall_1 !== 1'b1 || out_valid !== 1'b1 || out_id !== 8'h40) begin
                miscompares++;
                $display("FAIL bp.hold%0d got stall=%b v=%b id=%h want stall=1 v=1 id=40", i, out_stall_1, out_valid, out_id);
            end
            tick();
        end
        in_valid_1 = 1'b0; in_stall = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 8'h41 || out_stall_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp.rel0 got v=%b id=%h stall=%b want v=1 id=41 stall=0", out_valid, out_id, out_stall_1);
        end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_id !== 8'h42) begin miscompares++; $display("FAIL bp.rel1 got v=%b id=%h want v=1 id=42", out_valid, out_id); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp.rel2 valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush_under_stall;
        apply_reset();
        in_stall = 1'b1; in_valid_1 = 1'b1;
        in_id_1 = 8'h16; tick();
        in_id_1 = 8'h17; tick();
        in_valid_1 = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_id !== 8'h16) begin miscompares++; $display("FAIL fstall.pre got v=%b id=%h want v=1 id=16", out_valid, out_id); end
        flush_1 = 1'b1; flush_id_1 = 8'h16; tick(); flush_1 = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fstall.kill valid got %b want 0", out_valid); end
        vectors++; if (squash_cnt !== 8'd1) begin miscompares++; $display("FAIL fstall.cnt got %0d want 1", squash_cnt); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_id !== 8'h17) begin miscompares++; $display("FAIL fstall.next got v=%b id=%h want v=1 id=17", out_valid, out_id); end
        in_stall = 1'b0; tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fstall.drain valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush_fifo_push;
        apply_reset();
        in_stall = 1'b1; in_valid_1 = 1'b1;
        in_id_1 = 8'h13; tick();
        in_id_1 = 8'h14; tick();
        flush_1 = 1'b1; flush_id_1 = 8'h14; tick(); flush_1 = 1'b0;
        vectors++; if (squash_cnt !== 8'd1) begin miscompares++; $display("FAIL ffp.cnt got %0d want 1", squash_cnt); end
        vectors++; if (out_stall_1 !== 1'b1 || out_id !== 8'h13) begin miscompares++; $display("FAIL ffp.state got stall=%b id=%h want stall=1 id=13", out_stall_1, out_id); end
        in_stall = 1'b0; in_id_1 = 8'h15;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ffp.e3 valid got %b want 0", out_valid); end
        tick();
        in_id_1 = 8'h16;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ffp.e4 valid got %b want 0", out_valid); end
        tick();
        in_valid_1 = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_id !== 8'h15) begin miscompares++; $display("FAIL ffp.e5 got v=%b id=%h want v=1 id=15", out_valid, out_id); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_id !== 8'h16) begin miscompares++; $display("FAIL ffp.e6 got v=%b id=%h want v=1 id=16", out_valid, out_id); end
        tick();
        vectors++; if (out_valid !== 1'b0 || squash_cnt !== 8'd1) begin miscompares++; $display("FAIL ffp.e7 got v=%b cnt=%0d want v=0 cnt=1", out_valid, squash_cnt); end
    endtask

    task automatic test_dual_flush;
        apply_reset();
        in_stall = 1'b1; in_valid_1 = 1'b1; in_valid_2 = 1'b1;
        in_id_1 = 8'h50; in_id_2 = 8'h60; tick();
        in_valid_1 = 1'b0; in_valid_2 = 1'b0; tick();
        vectors++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_id !== 8'h50) begin miscompares++; $display("FAIL dual.pre got v=%b src=%b id=%h want v=1 src=0 id=50", out_valid, out_src, out_id); end
        flush_1 = 1'b1; flush_id_1 = 8'h50; flush_2 = 1'b1; flush_id_2 = 8'h60;
        tick();
        flush_1 = 1'b0; flush_2 = 1'b0;
        vectors++; if (out_valid !== 1'b0 || squash_cnt !== 8'd2) begin miscompares++; $display("FAIL dual.kill got v=%b cnt=%0d want v=0 cnt=2", out_valid, squash_cnt); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dual.after valid got %b want 0", out_valid); end
    endtask

    task automatic test_squash_saturate;
        logic seen_valid;
        apply_reset();
        seen_valid = 1'b0;
        for (int n = 0; n < 260; n++) begin
            in_valid_1 = 1'b1; in_id_1 = 8'h70; flush_1 = 1'b0;
            tick();
            seen_valid |= out_valid;
            in_valid_1 = 1'b0; flush_1 = 1'b1; flush_id_1 = 8'h70;
            tick();
            seen_valid |= out_valid;
            flush_1 = 1'b0;
            if (n == 199) begin
                vectors++; if (squash_cnt !== 8'd200) begin miscompares++; $display("FAIL sat.mid got %0d want 200", squash_cnt); end
            end
        end
        vectors++; if (squash_cnt !== 8'd255) begin miscompares++; $display("FAIL sat.end got %0d want 255", squash_cnt); end
        vectors++; if (seen_valid !== 1'b0) begin miscompares++; $display("FAIL sat.nogrant got %b want 0", seen_valid); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_reset_mid();
        test_single_channel();
        test_round_robin();
        test_back_pressure();
        test_flush_under_stall();
        test_flush_fifo_push();
        test_dual_flush();
        test_squash_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
